intr_ack_seq: RTL
=================

Name: intr_ack_seq

Overview:
- Processor-side handshake sequencer for INTR_CNTRL.
- Replaces hand-driven ack/bus timing. Detects `intr_out`, issues the two active-low acks and captures and validates the vector `{01011, id}`.
- Hands the 3-bit id to the core over a valid/ready pair, waits for ISR completion, then drives the EOI word `{10100, id}` with its ack strobe.
- In idle it drives the mode word (polling = 8'h01) onto the shared bus.

Parameters:
- ACK_DELAY, 4: cycles between the trigger event and each ack pulse; range 1..255.
- TIMEOUT, 64: max cycles to wait for the controller to drive the bus after ack1.
- HOLDOFF, 3: cycles `cntrl_intr` is ignored after EOI.
- VEC_PREFIX, 5'b01011: expected upper bits of the vector word.
- EOI_PREFIX, 5'b10100: upper bits of the EOI word.
- MODE_WORD, 8'h01: configuration word driven while idle.

Ports:
- clk_in, input, 1: clock; all logic on rising edge.
- rst_in, input, 1: asynchronous, active-high reset.
- cntrl_intr, input, 1: INTR_CNTRL `intr_out`.
- cntrl_bus_oe, input, 1: INTR_CNTRL `bus_oe` (controller owns the bus).
- cntrl_ack_n, output, 1: to INTR_CNTRL `intr_in`; active-low strobe.
- bus_in, input, 8: bus value as driven by the controller.
- bus_out, output, 8: value this block drives onto the bus.
- bus_drive, output, 1: tri-state enable for `bus_out`.
- irq_valid, output, 1: id available to the core.
- irq_id, output, 3: serviced interrupt id.
- irq_ready, input, 1: core accepts id.
- isr_done, input, 1: core finished ISR; single-cycle pulse.
- busy, output, 1: high in every state except IDLE.
- err_flag, output, 1: sticky protocol error.
- err_clr, input, 1: clears `err_flag`.

Behaviour:
- Reset values: `cntrl_ack_n`=1, `bus_out`=MODE_WORD, `bus_drive`=1, `irq_valid`=0, `irq_id`=0, `busy`=0, `err_flag`=0, state=IDLE, all counters 0.
- Contention rule: `bus_drive` = `drive_q` & ~`cntrl_bus_oe`. This is combinational and overrides every state, so both sides never drive the bus in the same cycle.
- IDLE:
  - Drive MODE_WORD.
  - If holdoff counter is 0 and `cntrl_intr`=1 → WAIT1, delay counter = ACK_DELAY-1.
- WAIT1: decrement; at 0 → ACK1.
- ACK1:
  - `cntrl_ack_n`=0 for exactly 1 cycle; `drive_q`=0.
  - → CAPT, timeout counter = TIMEOUT-1.
- CAPT:
  - First cycle with `cntrl_bus_oe`=1: sample `bus_in`.
  - If `bus_in[7:3]`==VEC_PREFIX: latch `irq_id`=`bus_in[2:0]` → WAIT2 (delay = ACK_DELAY-1).
  - Prefix mismatch → ERR.
  - Timeout counter reaching 0 with `cntrl_bus_oe`=0 → ERR.
- WAIT2: count down → ACK2.
- ACK2: `cntrl_ack_n`=0 for 1 cycle → DELIVER.
- DELIVER:
  - `irq_valid`=1 and held stable until the cycle `irq_ready`=1.
  - On that cycle the transfer completes; `irq_valid` drops next cycle → WAIT_ISR.
- WAIT_ISR:
  - Wait for `isr_done`=1.
  - `isr_done` arriving in DELIVER in the same cycle as `irq_ready` goes directly to EOI.
  - `isr_done` in any other state is ignored.
- EOI:
  - `bus_out`={EOI_PREFIX, `irq_id`}, `drive_q`=1, `cntrl_ack_n`=0 for 1 cycle.
  - Next cycle: `bus_out` returns to MODE_WORD, holdoff = HOLDOFF → IDLE.
- ERR:
  - Set `err_flag`, hold `cntrl_ack_n`=1, `drive_q`=1 with MODE_WORD → IDLE after 1 cycle.
  - `err_flag` stays set until `err_clr`; `err_clr` and a new error in the same cycle leaves the flag set.
- Latency: `cntrl_intr` rising → ack1 low after ACK_DELAY+1 cycles.
- `cntrl_intr` dropping mid-sequence does not abort; the sequence completes.
- Reset mid-sequence returns all outputs to reset values immediately (asynchronous).

Optional Feature:
- Macro: INTR_ACK_SEQ_STATS_EN.
- Defined:
  - Adds ports `stat_sel` (in, 3) and `stat_cnt` (out, 8).
  - Eight 8-bit saturating counters, incremented at EOI for `irq_id`; saturate at 8'hFF.
  - `stat_cnt` is a combinational read of counter[`stat_sel`]; cleared on reset.
- Undefined: ports absent, no counters.

Test Plan:
- Reset, then idle: `bus_drive`=1, `bus_out`=8'h01, `cntrl_ack_n`=1, `busy`=0 → all hold for 20 cycles.
- `cntrl_intr`↑; controller model drives 8'h5D on `bus_oe` → ack_n low 1 cycle at ACK_DELAY+1 (5 cycles with defaults), `irq_id`=3'b101, second ack, `irq_valid`=1. `irq_ready`, then `isr_done` → bus shows 8'hA5 with ack_n=0 for one cycle.
- Controller drives 8'h71 (bad prefix) → `err_flag`=1, no ack2, return to IDLE. `err_clr` → flag 0.
- Controller never asserts `bus_oe` after ack1 → `err_flag` set exactly TIMEOUT cycles after leaving ACK1.
- `cntrl_intr` held high through EOI → no new ack1 within HOLDOFF cycles; next sequence starts after holdoff. With `bus_oe`=1, `bus_drive` is always 0.
- STATS_EN: service id 2 three times → `stat_sel`=2 gives `stat_cnt`=3. 300 services of id 0 → `stat_cnt`=8'hFF.

Source files
------------

// File: rtl/intr_ack_seq.sv
// Processor-side handshake sequencer for INTR_CNTRL: ack/vector capture, id hand-off, EOI.
// Optional per-id service counters are built when INTR_ACK_SEQ_STATS_EN is defined.
module intr_ack_seq #(
  parameter int unsigned ACK_DELAY  = 4,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned HOLDOFF    = 3,
  parameter logic [4:0]  VEC_PREFIX = 5'b01011,
  parameter logic [4:0]  EOI_PREFIX = 5'b10100,
  parameter logic [7:0]  MODE_WORD  = 8'h01
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       cntrl_intr,
  input  logic       cntrl_bus_oe,
  output logic       cntrl_ack_n,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_drive,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  input  logic       irq_ready,
  input  logic       isr_done,
  output logic       busy,
  output logic       err_flag,
  input  logic       err_clr
`ifdef INTR_ACK_SEQ_STATS_EN
  ,
  input  logic [2:0] stat_sel,
  output logic [7:0] stat_cnt
`endif
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [7:0]      DLY_LOAD = 8'(ACK_DELAY - 1);
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT - 1);
  localparam logic [HO_W-1:0] HO_LOAD  = HO_W'(HOLDOFF);

  typedef enum logic [3:0] {
    IDLE,
    WAIT1,
    ACK1,
    CAPT,
    WAIT2,
    ACK2,
    DELIVER,
    WAIT_ISR,
    EOI,
    ERR
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      dlyCnt_q, dlyCnt_d;
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic [HO_W-1:0] hoCnt_q, hoCnt_d;
  logic            ackN_q, ackN_d;
  logic            drive_q, drive_d;
  logic [7:0]      busOut_q, busOut_d;
  logic            irqValid_q, irqValid_d;
  logic [2:0]      irqId_q, irqId_d;
  logic            errFlag_q, errFlag_d;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      dlyCnt_q   <= '0;
      toCnt_q    <= '0;
      hoCnt_q    <= '0;
      ackN_q     <= 1'b1;
      drive_q    <= 1'b1;
      busOut_q   <= MODE_WORD;
      irqValid_q <= 1'b0;
      irqId_q    <= '0;
      errFlag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dlyCnt_q   <= dlyCnt_d;
      toCnt_q    <= toCnt_d;
      hoCnt_q    <= hoCnt_d;
      ackN_q     <= ackN_d;
      drive_q    <= drive_d;
      busOut_q   <= busOut_d;
      irqValid_q <= irqValid_d;
      irqId_q    <= irqId_d;
      errFlag_q  <= errFlag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dlyCnt_d = dlyCnt_q;
    toCnt_d  = toCnt_q;
    hoCnt_d  = hoCnt_q;
    irqId_d  = irqId_q;

    case (state_q)
      IDLE: begin
        if (hoCnt_q != '0) begin
          hoCnt_d = hoCnt_q - HO_W'(1);
        end else if (cntrl_intr) begin
          state_d  = WAIT1;
          dlyCnt_d = DLY_LOAD;
        end
      end
      WAIT1: begin
        if (dlyCnt_q == 8'd0) state_d = ACK1;
        else                  dlyCnt_d = dlyCnt_q - 8'd1;
      end
      ACK1: begin
        state_d = CAPT;
        toCnt_d = TO_LOAD;
      end
      // A controller-driven word wins over an expiring timeout in the same cycle.
      CAPT: begin
        if (cntrl_bus_oe) begin
          if (bus_in[7:3] == VEC_PREFIX) begin
            irqId_d  = bus_in[2:0];
            state_d  = WAIT2;
            dlyCnt_d = DLY_LOAD;
          end else begin
            state_d = ERR;
          end
        end else if (toCnt_q == '0) begin
          state_d = ERR;
        end else begin
          toCnt_d = toCnt_q - TO_W'(1);
        end
      end
      WAIT2: begin
        if (dlyCnt_q == 8'd0) state_d = ACK2;
        else                  dlyCnt_d = dlyCnt_q - 8'd1;
      end
      ACK2: state_d = DELIVER;
      DELIVER: begin
        if (irq_ready) state_d = isr_done ? EOI : WAIT_ISR;
      end
      WAIT_ISR: begin
        if (isr_done) state_d = EOI;
      end
      EOI: begin
        state_d = IDLE;
        hoCnt_d = HO_LOAD;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so each one is glitch-free.
    ackN_d     = !(state_d inside {ACK1, ACK2, EOI});
    drive_d    = state_d inside {IDLE, WAIT1, EOI, ERR};
    busOut_d   = (state_d == EOI) ? {EOI_PREFIX, irqId_d} : MODE_WORD;
    irqValid_d = (state_d == DELIVER);
    errFlag_d  = (errFlag_q & ~err_clr) | (state_d == ERR);
  end

  assign cntrl_ack_n = ackN_q;
  assign bus_out     = busOut_q;
  assign bus_drive   = drive_q & ~cntrl_bus_oe;
  assign irq_valid   = irqValid_q;
  assign irq_id      = irqId_q;
  assign busy        = (state_q != IDLE);
  assign err_flag    = errFlag_q;

`ifdef INTR_ACK_SEQ_STATS_EN
  logic [7:0] statCnt_q [8];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 8; i++) statCnt_q[i] <= '0;
    end else if (state_q == EOI && statCnt_q[irqId_q] != 8'hFF) begin
      statCnt_q[irqId_q] <= statCnt_q[irqId_q] + 8'd1;
    end
  end

  assign stat_cnt = statCnt_q[stat_sel];
`endif

endmodule
